// File: rtl/caseg_to_bit.sv
// caseg_to_bit
//   Recovers the digit codes shown on a multiplexed 8-digit, common-anode
//   7-segment display by watching its select and segment lines. A digit is
//   captured once sel/seg have been stable for STABLE_CYC cycles. A full
//   frame is published once all eight digits have been captured.
//
// Ports
//   sclk         clock, rising edge
//   nrst         asynchronous active-low reset
//   sel[7:0]     digit select, active-low one-cold (bit 7 = leftmost digit)
//   seg[7:0]     segments, active-low, DP,G,F,E,D,C,B,A (bit 7..0)
//   bit_7..bit_0 decoded 4-bit codes of the last complete frame
//                (0-9 digits, 10 blank, 11 dash, 12 'A', 13 'P', 15 unknown)
//   dp_en[7:0]   decimal point lit per digit in the last complete frame
//   frame_valid  one-cycle pulse when bit_*/dp_en/frame_err update
//   frame_err    some digit of the last complete frame decoded to 15
//   stale        no capture for TIMEOUT cycles; cleared by the next frame
module caseg_to_bit #(
    parameter int unsigned STABLE_CYC = 16,
    parameter int unsigned TIMEOUT    = 2_000_000
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic [7:0] sel,
    input  logic [7:0] seg,
    output logic [3:0] bit_7,
    output logic [3:0] bit_6,
    output logic [3:0] bit_5,
    output logic [3:0] bit_4,
    output logic [3:0] bit_3,
    output logic [3:0] bit_2,
    output logic [3:0] bit_1,
    output logic [3:0] bit_0,
    output logic [7:0] dp_en,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale
);

    localparam logic [7:0]  STABLE_MAX = 8'(STABLE_CYC);
    localparam logic [23:0] TO_MAX     = 24'(TIMEOUT);

    // Input registers and previous-cycle copy used for change detection
    logic [7:0]  sel_q, sel_d;
    logic [7:0]  seg_q, seg_d;
    logic [15:0] prev_q, prev_d;

    logic [7:0]  stab_q, stab_d;
    logic [23:0] to_q, to_d;
    logic [7:0]  seen_q, seen_d;

    // Shadow frame, 4 bits per digit packed with digit 0 in the LSBs
    logic [31:0] sh_code_q, sh_code_d;
    logic [7:0]  sh_dp_q, sh_dp_d;

    logic [31:0] code_q, code_d;
    logic [7:0]  dp_en_q, dp_en_d;
    logic        frame_valid_q, frame_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        stale_q, stale_d;

    logic [7:0]  sel_n;
    logic        sel_ok;
    logic [2:0]  dig_idx;
    logic [3:0]  dec_code;
    logic        changed;
    logic        capture;
    logic        publish;
    logic        timeout_hit;
    logic        any_bad;

    // Select qualification: exactly one active-low bit
    always_comb begin
        sel_n   = ~sel_q;
        sel_ok  = (sel_n != '0) && ((sel_n & (sel_n - 8'd1)) == '0);
        dig_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sel_n[i]) begin
                dig_idx = 3'(i);
            end
        end
    end

    // Segment decode; DP (bit 7) never takes part in the match
    always_comb begin
        case (seg_q[6:0])
            7'h40:   dec_code = 4'd0;
            7'h79:   dec_code = 4'd1;
            7'h24:   dec_code = 4'd2;
            7'h30:   dec_code = 4'd3;
            7'h19:   dec_code = 4'd4;
            7'h12:   dec_code = 4'd5;
            7'h02:   dec_code = 4'd6;
            7'h78:   dec_code = 4'd7;
            7'h00:   dec_code = 4'd8;
            7'h10:   dec_code = 4'd9;
            7'h7F:   dec_code = 4'd10;
            7'h3F:   dec_code = 4'd11;
            7'h08:   dec_code = 4'd12;
            7'h0C:   dec_code = 4'd13;
            default: dec_code = 4'd15;
        endcase
    end

    always_comb begin
        sel_d  = sel;
        seg_d  = seg;
        prev_d = {sel_q, seg_q};

        changed = ({sel_q, seg_q} != prev_q);
        // Fires only on the STABLE_CYC-1 -> STABLE_CYC step, so once per dwell
        capture = sel_ok && !changed && (stab_q == STABLE_MAX - 8'd1);

        if (!sel_ok || changed) begin
            stab_d = '0;
        end else if (stab_q != STABLE_MAX) begin
            stab_d = stab_q + 8'd1;
        end else begin
            stab_d = stab_q;
        end

        // seen_q reaching all-ones means the previous cycle completed the frame
        publish = (seen_q == 8'hFF);

        if (capture) begin
            to_d = '0;
        end else if (to_q != TO_MAX) begin
            to_d = to_q + 24'd1;
        end else begin
            to_d = to_q;
        end
        timeout_hit = (to_d == TO_MAX);

        seen_d    = seen_q;
        sh_code_d = sh_code_q;
        sh_dp_d   = sh_dp_q;
        if (publish || timeout_hit) begin
            seen_d = '0;
        end
        if (capture) begin
            seen_d[dig_idx]                  = 1'b1;
            sh_code_d[{dig_idx, 2'b00} +: 4] = dec_code;
            sh_dp_d[dig_idx]                 = ~seg_q[7];
        end

        any_bad = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (sh_code_q[i*4 +: 4] == 4'd15) begin
                any_bad = 1'b1;
            end
        end

        frame_valid_d = publish;
        code_d        = code_q;
        dp_en_d       = dp_en_q;
        frame_err_d   = frame_err_q;
        if (publish) begin
            code_d      = sh_code_q;
            dp_en_d     = sh_dp_q;
            frame_err_d = any_bad;
        end

        if (publish) begin
            stale_d = 1'b0;
        end else if (timeout_hit) begin
            stale_d = 1'b1;
        end else begin
            stale_d = stale_q;
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            sel_q         <= '1;
            seg_q         <= '1;
            prev_q        <= '1;
            stab_q        <= '0;
            to_q          <= '0;
            seen_q        <= '0;
            sh_code_q     <= '0;
            sh_dp_q       <= '0;
            code_q        <= '0;
            dp_en_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            stale_q       <= 1'b0;
        end else begin
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            prev_q        <= prev_d;
            stab_q        <= stab_d;
            to_q          <= to_d;
            seen_q        <= seen_d;
            sh_code_q     <= sh_code_d;
            sh_dp_q       <= sh_dp_d;
            code_q        <= code_d;
            dp_en_q       <= dp_en_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            stale_q       <= stale_d;
        end
    end

    assign bit_0       = code_q[3:0];
    assign bit_1       = code_q[7:4];
    assign bit_2       = code_q[11:8];
    assign bit_3       = code_q[15:12];
    assign bit_4       = code_q[19:16];
    assign bit_5       = code_q[23:20];
    assign bit_6       = code_q[27:24];
    assign bit_7       = code_q[31:28];
    assign dp_en       = dp_en_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_caseg_to_bit.sv
// Bench for caseg_to_bit with STABLE_CYC=4, TIMEOUT=200.
module tb_caseg_to_bit;

    localparam int unsigned STABLE_CYC = 4;
    localparam int unsigned TIMEOUT    = 200;

    logic       sclk = 1'b0;
    logic       nrst;
    logic [7:0] sel;
    logic [7:0] seg;
    logic [3:0] bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0;
    logic [7:0] dp_en;
    logic       frame_valid;
    logic       frame_err;
    logic       stale;

    always #5 sclk = ~sclk;

    caseg_to_bit #(
        .STABLE_CYC(STABLE_CYC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sclk       (sclk),
        .nrst       (nrst),
        .sel        (sel),
        .seg        (seg),
        .bit_7      (bit_7),
        .bit_6      (bit_6),
        .bit_5      (bit_5),
        .bit_4      (bit_4),
        .bit_3      (bit_3),
        .bit_2      (bit_2),
        .bit_1      (bit_1),
        .bit_0      (bit_0),
        .dp_en      (dp_en),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .stale      (stale)
    );

    int   checks = 0;
    int   errors = 0;
    int   fv_cnt = 0;
    logic fv_stale = 1'b0;

    // Reference: code = index into this table (segment bytes with DP off)
    logic [7:0] pat [14] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82,
                             8'hF8, 8'h80, 8'h90, 8'hFF, 8'hBF, 8'h88, 8'h8C};

    // Model state. A capture takes effect one edge after the input has been
    // sampled unchanged and valid on STABLE_CYC+1 consecutive edges.
    int          m_run;
    logic [15:0] m_last;
    bit          m_cap_v;
    int          m_cap_k;
    logic [7:0]  m_cap_seg;
    logic [3:0]  m_sh_code [8];
    logic [7:0]  m_sh_dp;
    logic [7:0]  m_seen;
    bit          m_pub;
    logic [3:0]  m_code [8];
    logic [7:0]  m_dp;
    logic        m_fv, m_err, m_stale;
    int          m_idle;

    function automatic logic [3:0] ref_decode(input logic [7:0] s);
        logic [7:0] t;
        logic [3:0] r;
        t = s | 8'h80;
        r = 4'd15;
        for (int i = 0; i < 14; i++) begin
            if (pat[i] == t) r = 4'(i);
        end
        return r;
    endfunction

    function automatic int zeros(input logic [7:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) if (!s[i]) n++;
        return n;
    endfunction

    function automatic int zero_pos(input logic [7:0] s);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (!s[i]) p = i;
        return p;
    endfunction

    task automatic model_step();
        if (!nrst) begin
            m_run = 0; m_last = '1; m_cap_v = 0; m_cap_k = 0; m_cap_seg = '1;
            for (int i = 0; i < 8; i++) begin
                m_sh_code[i] = '0;
                m_code[i]    = '0;
            end
            m_sh_dp = '0; m_seen = '0; m_pub = 0; m_dp = '0;
            m_fv = 1'b0; m_err = 1'b0; m_stale = 1'b0; m_idle = 0;
        end else begin
            m_fv = 1'b0;
            if (m_pub) begin
                m_err = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    m_code[i] = m_sh_code[i];
                    if (m_sh_code[i] == 4'd15) m_err = 1'b1;
                end
                m_dp = m_sh_dp; m_fv = 1'b1; m_stale = 1'b0;
                m_seen = '0; m_pub = 0;
            end
            if (m_cap_v) begin
                m_sh_code[m_cap_k] = ref_decode(m_cap_seg);
                m_sh_dp[m_cap_k]   = ~m_cap_seg[7];
                m_seen[m_cap_k]    = 1'b1;
                m_idle = 0;
                if (m_seen == 8'hFF) m_pub = 1;
            end else begin
                if (m_idle < int'(TIMEOUT)) m_idle++;
                if (m_idle == int'(TIMEOUT)) begin
                    m_stale = 1'b1;
                    m_seen  = '0;
                end
            end
            if (zeros(sel) == 1) begin
                if ({sel, seg} == m_last && m_run > 0) begin
                    if (m_run < 1000) m_run++;
                end else begin
                    m_run = 1;
                end
            end else begin
                m_run = 0;
            end
            m_last    = {sel, seg};
            m_cap_v   = (m_run == int'(STABLE_CYC) + 1);
            m_cap_k   = zero_pos(sel);
            m_cap_seg = seg;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_word();
        return {bit_7, bit_6, bit_5, bit_4, bit_3, bit_2, bit_1, bit_0};
    endfunction

    function automatic logic [42:0] dut_all();
        return {dut_word(), dp_en, frame_valid, frame_err, stale};
    endfunction

    function automatic logic [42:0] model_all();
        return {m_code[7], m_code[6], m_code[5], m_code[4], m_code[3], m_code[2],
                m_code[1], m_code[0], m_dp, m_fv, m_err, m_stale};
    endfunction

    task automatic tick();
        @(posedge sclk);
        model_step();
        @(negedge sclk);
        check("outputs_vs_model", 64'(dut_all()), 64'(model_all()));
        if (frame_valid) begin
            fv_cnt++;
            fv_stale = stale;
        end
    endtask

    task automatic hold(input logic [7:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg = g;
        repeat (n) tick();
    endtask

    // segs holds the segment byte for digit k in bits [8k+7:8k]
    task automatic scan(input int lo, input int hi, input logic [63:0] segs);
        for (int k = lo; k <= hi; k++) begin
            hold(~(8'd1 << k), segs[k*8 +: 8], 10);
        end
    endtask

    localparam logic [63:0] STD   = 64'hF8_82_92_99_B0_A4_F9_C0;
    localparam logic [63:0] BAD3  = 64'hF8_82_92_99_AA_A4_F9_C0;
    localparam logic [63:0] MIXED = 64'hF9_C0_8C_88_BF_7F_90_80;
    localparam logic [63:0] DESC  = 64'hA4_B0_99_92_82_F8_80_90;
    localparam logic [63:0] ALL_A = 64'h88_88_88_88_88_88_88_88;

    initial begin
        nrst = 1'b0;
        sel  = '1;
        seg  = '1;
        repeat (3) tick();
        check("reset_outputs", 64'(dut_all()), 64'd0);
        nrst = 1'b1;
        repeat (2) tick();

        // Plain scan of 0..7
        fv_cnt = 0;
        scan(0, 7, STD);
        repeat (2) tick();
        check("scan_fv_count", 64'(fv_cnt), 64'd1);
        check("scan_codes", 64'(dut_word()), 64'h76543210);
        check("scan_dp", 64'(dp_en), 64'h00);
        check("scan_err", 64'(frame_err), 64'd0);

        // Too-short dwell, then a seg change, then an exact-length dwell
        fv_cnt = 0;
        scan(1, 7, STD);
        hold(8'hFE, 8'h40, 3);
        hold(8'hFE, 8'hC0, 3);
        check("short_dwell_fv", 64'(fv_cnt), 64'd0);
        hold(8'hFE, 8'h40, 5);
        hold(8'hFF, 8'hFF, 4);
        check("dwell_fv_count", 64'(fv_cnt), 64'd1);
        check("dwell_codes", 64'(dut_word()), 64'h76543210);
        check("dwell_dp", 64'(dp_en), 64'h01);

        // Unknown pattern on digit 3, then a clean frame using the rest of the table
        fv_cnt = 0;
        scan(0, 7, BAD3);
        repeat (2) tick();
        check("bad_codes", 64'(dut_word()), 64'h7654F210);
        check("bad_err", 64'(frame_err), 64'd1);
        scan(0, 7, MIXED);
        repeat (2) tick();
        check("mixed_fv_count", 64'(fv_cnt), 64'd2);
        check("mixed_codes", 64'(dut_word()), 64'h10DCBA98);
        check("mixed_dp", 64'(dp_en), 64'h04);
        check("mixed_err", 64'(frame_err), 64'd0);

        // Invalid selects mid-frame must not capture nor disturb progress
        fv_cnt = 0;
        scan(0, 3, STD);
        hold(8'h00, 8'hC0, 50);
        hold(8'hFC, 8'hC0, 50);
        check("invalid_sel_fv", 64'(fv_cnt), 64'd0);
        scan(4, 7, STD);
        repeat (2) tick();
        check("invalid_sel_fv_after", 64'(fv_cnt), 64'd1);
        check("invalid_sel_codes", 64'(dut_word()), 64'h76543210);

        // Timeout discards a partial frame; stale clears only with a frame
        fv_cnt = 0;
        scan(0, 4, STD);
        hold(8'hFF, 8'hFF, 210);
        check("timeout_stale", 64'(stale), 64'd1);
        check("timeout_fv", 64'(fv_cnt), 64'd0);
        scan(5, 7, DESC);
        check("partial_after_timeout_fv", 64'(fv_cnt), 64'd0);
        check("stale_held_by_capture", 64'(stale), 64'd1);
        scan(0, 4, DESC);
        repeat (2) tick();
        check("recover_fv_count", 64'(fv_cnt), 64'd1);
        check("recover_stale_at_fv", 64'(fv_stale), 64'd0);
        check("recover_codes", 64'(dut_word()), 64'h23456789);

        // Reset mid-frame
        fv_cnt = 0;
        scan(0, 5, ALL_A);
        nrst = 1'b0;
        sel  = '1;
        seg  = '1;
        repeat (3) tick();
        check("midreset_outputs", 64'(dut_all()), 64'd0);
        nrst = 1'b1;
        tick();
        scan(0, 7, STD);
        repeat (2) tick();
        check("post_reset_fv_count", 64'(fv_cnt), 64'd1);
        check("post_reset_codes", 64'(dut_word()), 64'h76543210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/caseg_to_bit.md
CASEG_TO_BIT -- requirements
Module: caseg_to_bit

Interface
REQ-001 Parameter STABLE_CYC, default 16: consecutive unchanged cycles of sel/seg required before a digit is captured; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 2_000_000: cycles without any capture before the display is declared stale; legal range 2..2^24-1.
REQ-003 sclk  input  1  clock; all logic on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 sel  input  8  digit select, active-low one-cold; sel[k]=0 selects digit k, bit 7 leftmost.
REQ-006 seg  input  8  segment lines, active-low, order DP,G,F,E,D,C,B,A (bit 7..0).
REQ-007 bit_7..bit_0  output  4 each  decoded digit codes of last complete frame.
REQ-008 dp_en  output  8  dp_en[k]=1 means digit k showed its decimal point in last complete frame.
REQ-009 frame_valid  output  1  one-cycle pulse when bit_*/dp_en/frame_err update.
REQ-010 frame_err  output  1  1 if any digit of the last complete frame decoded to code 15.
REQ-011 stale  output  1  1 while no capture has occurred for TIMEOUT cycles.

Function
REQ-012 sel and seg SHALL be registered once (sel_r, seg_r) before any use; all latencies below count from the sclk edge on which new values are registered.
REQ-013 sel_r is valid only when exactly one bit is 0; 8'hFF, 8'h00 and any multi-zero value SHALL be ignored and SHALL hold the stability counter at 0.
REQ-014 Stability counter: reset to 0 on any change of {sel_r,seg_r} or invalid sel_r; otherwise increment, saturating at STABLE_CYC.
REQ-015 Capture SHALL occur on the single cycle in which the counter transitions STABLE_CYC-1 -> STABLE_CYC; exactly one capture per stable dwell.
REQ-016 Capture of digit k SHALL write shadow code[k], shadow dp[k] = ~seg_r[7], and set seen[k]; re-capture of a digit already seen in the current frame overwrites its shadow.
REQ-017 Decode of seg_r[6:0] (table in full-byte form with DP off): C0->0, F9->1, A4->2, B0->3, 99->4, 92->5, 82->6, F8->7, 80->8, 90->9, FF->10 (blank), BF->11 (dash), 88->12 (A), 8C->13 (P); any other pattern -> 15; code 14 SHALL never be produced.
REQ-018 DP is independent of decode: the table match SHALL ignore seg_r[7].
REQ-019 When the capture sets the last missing bit of seen (seen becomes 8'hFF), on the next cycle: bit_k <= shadow code[k], dp_en <= shadow dp, frame_err <= OR over k of (code[k]==15), frame_valid=1 for one cycle, seen <= 0.
REQ-020 Outputs bit_*/dp_en/frame_err SHALL hold between frame_valid pulses.
REQ-021 Digit order within a frame is irrelevant; frame completes on first full coverage of all 8 digits.
REQ-022 Timeout counter: cleared on every capture, else incremented, saturating; on reaching TIMEOUT, stale <= 1 and seen <= 0 (partial frame discarded).
REQ-023 stale SHALL clear on the cycle frame_valid is asserted; a capture alone does not clear stale.
REQ-024 Capture and timeout in the same cycle: the capture wins (timeout counter cleared, seen updated, stale unchanged).

Reset
REQ-025 While nrst=0: sel_r=8'hFF, seg_r=8'hFF, counters 0, seen=0, shadows 0, bit_7..bit_0=0, dp_en=0, frame_valid=0, frame_err=0, stale=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; after release the first frame_valid requires all 8 digits to be recaptured.

Verification (STABLE_CYC=4, TIMEOUT=200)
REQ-027 Scan digits 0..7 with seg C0,F9,A4,B0,99,92,82,F8, each held 10 cycles -> one frame_valid 1 cycle after the 8th capture; bit_0..bit_7 = 0..7, dp_en=0, frame_err=0.
REQ-028 Hold sel=8'hFE, seg=8'h40 (0 with DP) 3 cycles then change seg -> no capture; holding 5 cycles -> exactly one capture, later dp_en[0]=1, bit_0=0.
REQ-029 One digit with seg=8'hAA, others valid -> its bit_k=15, frame_err=1 in that frame; next clean frame -> frame_err=0.
REQ-030 sel=8'h00 and sel=8'hFC held 50 cycles -> no capture, seen unchanged, no frame_valid.
REQ-031 Capture 5 digits then idle 200 cycles -> stale=1, no frame_valid; then full 8-digit scan -> frame_valid, stale=0 same cycle, first 5 digits' stale shadows not reused without recapture.
REQ-032 Pull nrst low after 6 captures, release, scan 8 digits -> exactly one frame_valid, all outputs from post-reset captures.
